// File: rtl/dram_loader_pkg.sv
// Shared definitions for the IR dispatch RAM (DRAM) loader and the IR board's unpacking.
//   DRAM_SIZE / DRAM_WIDTH : 512 words of 15 bits.
//   tDramOp                : load command opcodes; encodings 5-7 are illegal.
//   tDramWord              : stored word layout {A, B, PAR, J1_4, J7_10}, A in the MSBs.
//   state_e                : loader FSM states. The verify states exist only when
//                            DRAM_LOADER_VERIFY_EN is defined.
package dram_pkg;

  localparam int unsigned DRAM_SIZE  = 512;
  localparam int unsigned DRAM_WIDTH = 15;

  typedef enum logic [2:0] {
    LD_ADR = 3'd0,
    LD_AB  = 3'd1,
    LD_J   = 3'd2,
    WRITE  = 3'd3,
    READ   = 3'd4
  } tDramOp;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       par;
    logic [3:0] j1_4;
    logic [3:0] j7_10;
  } tDramWord;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRsp
`ifdef DRAM_LOADER_VERIFY_EN
    ,
    StVfyRd,
    StVfyCmp
`endif
  } state_e;

endpackage

// File: rtl/dram_loader_if.sv
// Bus bundle for dram_loader.
//   cmd_*  : load command channel (valid/ready), driven by the diagnostic decode.
//   rsp_*  : read response channel (valid/ready), consumed by the diagnostic decode.
//   dram_* : DRAM memory port A (addra/dina/wea/ena/douta), 1-clock read latency.
// Modports: slave = loader side, master = front-end / memory side.
interface dram_loader_if #(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned WORD_BITS = 15
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [ADDR_BITS-1:0] cmd_data;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_BITS-1:0] rsp_data;

  logic [ADDR_BITS-1:0] dram_addr;
  logic [WORD_BITS-1:0] dram_din;
  logic                 dram_wea;
  logic                 dram_ena;
  logic [WORD_BITS-1:0] dram_dout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, dram_dout,
    output cmd_ready, rsp_valid, rsp_data, dram_addr, dram_din, dram_wea, dram_ena
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, dram_dout,
    input  cmd_ready, rsp_valid, rsp_data, dram_addr, dram_din, dram_wea, dram_ena
  );
endinterface

// File: rtl/dram_loader_word_pack.sv
// dram_word_pack: combinational packer for one DRAM word.
//   a, b         : A and B fields (3 bits each).
//   j1_4, j7_10  : J field halves (4 bits each).
//   word         : packed tDramWord with PAR chosen so the 15 stored bits have odd parity.
module dram_word_pack
  import dram_pkg::*;
(
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [3:0] j1_4,
  input  logic [3:0] j7_10,
  output tDramWord   word
);

  always_comb begin
    word       = '0;
    word.a     = a;
    word.b     = b;
    word.j1_4  = j1_4;
    word.j7_10 = j7_10;
    word.par   = ~^{a, b, j1_4, j7_10};
  end

endmodule

// File: rtl/dram_loader.sv
// dram_loader: write side of the 512 x 15 IR dispatch RAM.
//   clk, reset : single clock (same as the DRAM), synchronous active-high reset.
//   bus        : dram_loader_if.slave - command channel, read response channel, DRAM port A.
//   err        : sticky error (illegal op; verify mismatch when enabled).
//   cur_addr   : current load address.
// Optional feature: define DRAM_LOADER_VERIFY_EN to read back and compare every write.
// cmd_data bit numbering: the operand's bit 8 is the LSB, so LD_AB uses the low 6 bits and
// LD_J the low 8 bits.
module dram_loader
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned WORD_BITS = DRAM_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  dram_loader_if.slave         bus,
  output logic                 err,
  output logic [ADDR_BITS-1:0] cur_addr
);

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [5:0]            ab_q, ab_d;
  logic [7:0]            j_q, j_d;
  logic                  err_q, err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORD_BITS-1:0]  rsp_data_q, rsp_data_d;

  tDramWord              word;
  logic [WORD_BITS-1:0]  word_bits;

  dram_word_pack u_pack (
    .a     (ab_q[5:3]),
    .b     (ab_q[2:0]),
    .j1_4  (j_q[7:4]),
    .j7_10 (j_q[3:0]),
    .word  (word)
  );

  assign word_bits     = WORD_BITS'(word);
  assign err           = err_q;
  assign cur_addr      = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    ab_d          = ab_q;
    j_d           = j_q;
    err_d         = err_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    bus.cmd_ready = 1'b0;
    bus.dram_ena  = 1'b0;
    bus.dram_wea  = 1'b0;
    bus.dram_addr = '0;
    bus.dram_din  = '0;

    unique case (state_q)
      StIdle: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (tDramOp'(bus.cmd_op))
            LD_ADR:  addr_d  = bus.cmd_data;
            LD_AB:   ab_d    = bus.cmd_data[5:0];
            LD_J:    j_d     = bus.cmd_data[7:0];
            WRITE:   state_d = StWr;
            READ:    state_d = StRd;
            default: err_d   = 1'b1;  // consumed, no memory access
          endcase
        end
      end

      StWr: begin
        bus.dram_ena  = 1'b1;
        bus.dram_wea  = 1'b1;
        bus.dram_addr = addr_q;
        bus.dram_din  = word_bits;
        addr_d        = addr_q + ADDR_BITS'(1);  // 511 wraps to 0
`ifdef DRAM_LOADER_VERIFY_EN
        state_d       = StVfyRd;
`else
        state_d       = StIdle;
`endif
      end

`ifdef DRAM_LOADER_VERIFY_EN
      StVfyRd: begin
        // addr_q already points past the word just written.
        bus.dram_ena  = 1'b1;
        bus.dram_addr = addr_q - ADDR_BITS'(1);
        state_d       = StVfyCmp;
      end

      StVfyCmp: begin
        // Holding registers cannot change while busy, so word_bits is still the written word.
        if (bus.dram_dout != word_bits) err_d = 1'b1;
        state_d = StIdle;
      end
`endif

      StRd: begin
        bus.dram_ena  = 1'b1;
        bus.dram_addr = addr_q;
        state_d       = StRsp;
      end

      StRsp: begin
        // First RSP cycle: douta holds the word addressed in RD; capture it so the
        // response stays stable however long the consumer stalls.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.dram_dout;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      ab_q        <= '0;
      j_q         <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ab_q        <= ab_d;
      j_q         <= j_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
